// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial two's-complement adder/subtractor, one bit per clock, LSB first.
// A single full_adder with a registered carry does all the arithmetic.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             overflow_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d, sh_r_q, sh_r_d, result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cy_q, cy_d, carry_q, carry_d, ovf_q, ovf_d;
    logic             sum, cout, accept, last;

    full_adder u_fa (
        .a_i(sh_a_q[0]),
        .b_i(sh_b_q[0]),
        .c_i(cy_q),
        .s_o(sum),
        .c_o(cout)
    );

    assign accept = start_i && state_q != RUN;
    assign last   = state_q == RUN && cnt_q == CW'(WIDTH - 1);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (accept)                state_d = RUN;
        else if (last)             state_d = DONE;
        else if (state_q == DONE)  state_d = IDLE;
    end

    always_comb begin
        busy_o     = state_q == RUN;
        done_o     = state_q == DONE;
        result_o   = result_q;
        carry_o    = carry_q;
        overflow_o = ovf_q;
    end

    // Subtraction is A + ~B + 1: invert B on load and seed the carry with sub_i.
    always_comb begin
        sh_a_d   = sh_a_q;
        sh_b_d   = sh_b_q;
        sh_r_d   = sh_r_q;
        cnt_d    = cnt_q;
        cy_d     = cy_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        if (accept) begin
            sh_a_d = a_i;
            sh_b_d = b_i ^ {WIDTH{sub_i}};
            cy_d   = sub_i;
            cnt_d  = '0;
        end else if (state_q == RUN) begin
            sh_a_d = sh_a_q >> 1;
            sh_b_d = sh_b_q >> 1;
            sh_r_d = {sum, sh_r_q[WIDTH-1:1]};
            cy_d   = cout;
            cnt_d  = cnt_q + 1'b1;
        end
        if (last) begin
            result_d = {sum, sh_r_q[WIDTH-1:1]};
            carry_d  = cout;
            ovf_d    = cy_q ^ cout;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            sh_r_q   <= '0;
            cnt_q    <= '0;
            cy_q     <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            sh_a_q   <= sh_a_d;
            sh_b_q   <= sh_b_d;
            sh_r_q   <= sh_r_d;
            cnt_q    <= cnt_d;
            cy_q     <= cy_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
        end
    end
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: checks the serial adder/subtractor at WIDTH=8 and WIDTH=2
// against an integer-arithmetic reference model.
module tb_serial_add_sub;
    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic       rst_i = 1'b1;
    logic       start8 = 1'b0, sub8 = 1'b0, busy8, done8, carry8, ovf8;
    logic [7:0] a8 = '0, b8 = '0, res8;
    logic       start2 = 1'b0, sub2 = 1'b0, busy2, done2, carry2, ovf2;
    logic [1:0] a2 = '0, b2 = '0, res2;
    int         checks = 0, errors = 0;
    time        t_done, t1;

    serial_add_sub #(.WIDTH(8)) dut8 (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start8), .sub_i(sub8), .a_i(a8), .b_i(b8),
        .busy_o(busy8), .done_o(done8), .result_o(res8), .carry_o(carry8), .overflow_o(ovf8)
    );

    serial_add_sub #(.WIDTH(2)) dut2 (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start2), .sub_i(sub2), .a_i(a2), .b_i(b2),
        .busy_o(busy2), .done_o(done2), .result_o(res2), .carry_o(carry2), .overflow_o(ovf2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {overflow, carry, result[w-1:0]} from plain integer arithmetic.
    function automatic logic [31:0] model(input int w, input longint a, input longint b, input logic sub);
        longint m, s, sa, sb, t, lim;
        logic   ov;
        m   = (longint'(1) << w) - 1;
        lim = longint'(1) << (w - 1);
        s   = a + (sub ? (~b & m) : b) + longint'(sub);
        sa  = a >= lim ? a - (m + 1) : a;
        sb  = b >= lim ? b - (m + 1) : b;
        t   = sub ? sa - sb : sa + sb;
        ov  = t < -lim || t >= lim;
        model = 32'(s & m) | (32'((s >> w) & 1) << w) | (32'(ov) << (w + 1));
    endfunction

    // Called just after a negedge; returns at the negedge where done8 is seen.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic noisy);
        logic [31:0] e;
        int          n, nb;
        e = model(8, a, b, sub);
        a8 = a; b8 = b; sub8 = sub; start8 = 1'b1;
        @(negedge clk_i);
        n = 0; nb = 0;
        while (!done8 && n < 20) begin
            if (busy8) nb++;
            start8 = noisy; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
            @(negedge clk_i);
            n++;
        end
        start8 = 1'b0;
        t_done = $time;
        check("lat8", n, 8);
        check("busy8", nb, 8);
        check("res8", res8, e[7:0]);
        check("carry8", carry8, e[8]);
        check("ovf8", ovf8, e[9]);
    endtask

    task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic sub);
        logic [31:0] e;
        int          n;
        e = model(2, a, b, sub);
        a2 = a; b2 = b; sub2 = sub; start2 = 1'b1;
        @(negedge clk_i);
        start2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom); sub2 = 1'($urandom);
        n = 0;
        while (!done2 && n < 10) begin
            @(negedge clk_i);
            n++;
        end
        check("lat2", n, 2);
        check("res2", res2, e[1:0]);
        check("carry2", carry2, e[2]);
        check("ovf2", ovf2, e[3]);
    endtask

    typedef struct { logic [7:0] a, b; logic sub; logic [7:0] r; logic c, v; } vec_t;
    vec_t vecs[5] = '{
        '{8'h3C, 8'h45, 1'b0, 8'h81, 1'b0, 1'b1},
        '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0},
        '{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0},
        '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0},
        '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1}
    };

    initial begin
        repeat (2) @(negedge clk_i);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_res", res8, 0);
        check("rst_carry", carry8, 0);
        check("rst_ovf", ovf8, 0);
        rst_i = 1'b0;
        @(negedge clk_i);
        foreach (vecs[i]) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].sub, 1'b0);
            check("tp_res", res8, vecs[i].r);
            check("tp_carry", carry8, vecs[i].c);
            check("tp_ovf", ovf8, vecs[i].v);
            @(negedge clk_i);
            check("idle_done", done8, 0);
            check("idle_busy", busy8, 0);
            check("hold_res", res8, vecs[i].r);
        end
        op8(8'h12, 8'h34, 1'b0, 1'b1);
        check("noisy_res", res8, 8'h46);
        @(negedge clk_i);
        op8(8'h01, 8'h02, 1'b0, 1'b0);
        t1 = t_done;
        op8(8'h50, 8'h20, 1'b1, 1'b0);
        check("b2b_gap", 32'((t_done - t1) / 10), 9);
        check("b2b_res", res8, 8'h30);
        @(negedge clk_i);
        a8 = 8'h11; b8 = 8'h22; sub8 = 1'b0; start8 = 1'b1;
        @(negedge clk_i);
        start8 = 1'b0;
        repeat (4) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("abort_busy", busy8, 0);
        check("abort_done", done8, 0);
        check("abort_res", res8, 0);
        check("abort_carry", carry8, 0);
        check("abort_ovf", ovf8, 0);
        @(negedge clk_i);
        check("abort_nodone", done8, 0);
        op8(8'h7F, 8'h01, 1'b0, 1'b0);
        check("post_res", res8, 8'h80);
        check("post_ovf", ovf8, 1);
        repeat (1000) begin
            if ($urandom_range(1) == 1) @(negedge clk_i);
            op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        end
        @(negedge clk_i);
        repeat (1000) begin
            if ($urandom_range(1) == 1) @(negedge clk_i);
            op2(2'($urandom), 2'($urandom), 1'($urandom));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
